// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and constants for the T-flip-flop counter controller.
package tff_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_count_ctrl_tff_cell.sv
// Single T flip-flop storage cell with synchronous active-high reset.
module tff_sync_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Start/stop/pause controller for an up/down counter built only from T cells;
// every count change, including the initial load, is a toggle vector.
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] lim_q;
  logic             dir_q;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] step_t;
  logic [WIDTH-1:0] init_val;
  logic [WIDTH-1:0] term_val;
  logic             capture;

  // Ripple-carry / ripple-borrow toggle patterns for a single step.
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      up_t[i] = up_t[i-1] & count[i-1];
      dn_t[i] = dn_t[i-1] & ~count[i-1];
    end
  end

  assign step_t   = (dir_q == DIR_UP) ? up_t : dn_t;
  assign init_val = (dir == DIR_UP) ? '0 : limit;
  assign term_val = (dir_q == DIR_UP) ? lim_q : '0;

  // Next state and toggle vector; stop outranks pause, pause outranks step.
  always_comb begin
    state_nxt = state;
    t_vec     = '0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          capture   = 1'b1;
          t_vec     = count ^ init_val;
          state_nxt = (limit == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (pause) begin
          state_nxt = ST_PAUSED;
        end else if (count == term_val) begin
          state_nxt = ST_DONE;
        end else begin
          t_vec = step_t;
          if ((count ^ step_t) == term_val) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_PAUSED: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (!pause) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, captured run parameters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      lim_q <= '0;
      dir_q <= DIR_DOWN;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        lim_q <= limit;
        dir_q <= dir;
      end
      busy <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSED);
      done <= (state_nxt == ST_DONE);
    end
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    tff_sync_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t_vec[g]),
      .q     (count[g])
    );
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed self-checking bench for tff_count_ctrl at WIDTH=4.
module tb_tff_count_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic       dir;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int total;
  int bad;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .dir   (dir),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || 2'(dut.state) !== 2'd0) begin
      bad++;
      $display("FAIL reset: count=%0d busy=%b done=%b state=%0d want 0/0/0/0",
               count, busy, done, 2'(dut.state));
    end
  endtask

  task automatic test_count_up();
    dir = 1'b1; limit = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    dir = 1'b0; limit = 4'd2;  // must not affect the running sequence
    total++;
    if (count !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL up_start: count=%0d busy=%b done=%b want 0/1/0", count, busy, done);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (count !== 4'(k) || busy !== (k < 5) || done !== (k == 5)) begin
        bad++;
        $display("FAIL up_step%0d: count=%0d busy=%b done=%b want %0d/%b/%b",
                 k, count, busy, done, k, (k < 5), (k == 5));
      end
    end
    tick();
    total++;
    if (count !== 4'd5 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL up_after: count=%0d busy=%b done=%b want 5/0/0", count, busy, done);
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_cnt;
    dir = 1'b0; limit = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (count !== 4'd15 || busy !== 1'b1) begin
      bad++;
      $display("FAIL down_load: count=%0d busy=%b want 15/1", count, busy);
    end
    for (int k = 14; k >= 0; k--) begin
      if (k == 7) begin
        total++;
        if (dut.t_vec !== 4'b1111) begin
          bad++;
          $display("FAIL down_t_8to7: t=%b want 1111", dut.t_vec);
        end
      end
      tick();
      exp_cnt = 4'(k);
      total++;
      if (count !== exp_cnt || done !== (k == 0)) begin
        bad++;
        $display("FAIL down_step%0d: count=%0d done=%b want %0d/%b",
                 k, count, done, k, (k == 0));
      end
    end
    tick();
    tick();
    total++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL down_nowrap: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_pause();
    dir = 1'b1; limit = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    pause = 1'b1;
    start = 1'b1;  // ignored while paused
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (count !== 4'd4 || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL pause_hold%0d: count=%0d busy=%b done=%b want 4/1/0",
                 k, count, busy, done);
      end
    end
    pause = 1'b0;
    start = 1'b0;
    tick();
    total++;
    if (count !== 4'd4 || busy !== 1'b1 || 2'(dut.state) !== 2'd1) begin
      bad++;
      $display("FAIL pause_resume: count=%0d busy=%b state=%0d want 4/1/1",
               count, busy, 2'(dut.state));
    end
    tick();
    total++;
    if (count !== 4'd5) begin
      bad++;
      $display("FAIL pause_step: count=%0d want 5", count);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_stop();
    dir = 1'b1; limit = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    stop = 1'b1;
    pause = 1'b1;
    tick();
    pause = 1'b0;
    stop = 1'b0;
    total++;
    if (count !== 4'd3 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL stop_run: count=%0d busy=%b done=%b want 3/0/0", count, busy, done);
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    total++;
    if (count !== 4'd3 || busy !== 1'b0 || done !== 1'b0 || 2'(dut.state) !== 2'd0) begin
      bad++;
      $display("FAIL start_stop_idle: count=%0d busy=%b done=%b state=%0d want 3/0/0/0",
               count, busy, done, 2'(dut.state));
    end
  endtask

  task automatic test_limit_zero();
    dir = 1'b0; limit = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (count !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL lim0_done: count=%0d done=%b busy=%b want 0/1/0", count, done, busy);
    end
    tick();
    total++;
    if (done !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("FAIL lim0_after: count=%0d done=%b want 0/0", count, done);
    end
  endtask

  task automatic test_reset_mid();
    dir = 1'b1; limit = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    total++;
    if (count !== 4'd6) begin
      bad++;
      $display("FAIL mid_pre: count=%0d want 6", count);
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    total++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || 2'(dut.state) !== 2'd0 ||
        dut.lim_q !== 4'd0 || dut.dir_q !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: count=%0d busy=%b done=%b state=%0d lim=%0d dir=%b want 0/0/0/0/0/0",
               count, busy, done, 2'(dut.state), dut.lim_q, dut.dir_q);
    end
  endtask

  task automatic test_back_to_back();
    dir = 1'b1; limit = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (count !== 4'd2 || done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done: count=%0d done=%b want 2/1", count, done);
    end
    start = 1'b1; dir = 1'b0; limit = 4'd3;
    tick();
    total++;
    if (count !== 4'd2 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ignore: count=%0d busy=%b done=%b want 2/0/0", count, busy, done);
    end
    tick();
    start = 1'b0;
    total++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_reload: count=%0d busy=%b want 3/1", count, busy);
    end
    tick();
    total++;
    if (count !== 4'd2) begin
      bad++;
      $display("FAIL b2b_step: count=%0d want 2", count);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0; limit = 4'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_pause();
    test_stop();
    test_limit_zero();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
